// File: rtl/host_bram_arbiter_if.sv
// -----------------------------------------------------------------------------
// host_bram_arbiter_if
// Bus bundle between the host BRAM port / kernel requesters and the arbiter.
//   master : host + kernel side (drives strobes, addresses, write data)
//   slave  : arbiter side (drives host_dout, req_ready, rsp_valid, rsp_rdata)
// Signals:
//   host_en, host_we[NB], host_addr[ADDR_W], host_din[DATA_W], host_dout[DATA_W]
//   req_valid[NUM_REQ], req_ready[NUM_REQ], req_we[NUM_REQ*NB],
//   req_addr[NUM_REQ*WADDR_W], req_wdata[NUM_REQ*DATA_W],
//   rsp_valid[NUM_REQ], rsp_rdata[DATA_W]
// Per-requester fields are packed with requester 0 in the least-significant slot.
// -----------------------------------------------------------------------------
interface host_bram_arbiter_if #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 2,
    parameter int WADDR_W = ADDR_W - 2
);
    localparam int NB = DATA_W / 8;

    logic                       host_en;
    logic [NB-1:0]              host_we;
    logic [ADDR_W-1:0]          host_addr;
    logic [DATA_W-1:0]          host_din;
    logic [DATA_W-1:0]          host_dout;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*NB-1:0]      req_we;
    logic [NUM_REQ*WADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_wdata;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [DATA_W-1:0]          rsp_rdata;

    modport master (
        output host_en, host_we, host_addr, host_din,
        output req_valid, req_we, req_addr, req_wdata,
        input  host_dout, req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  host_en, host_we, host_addr, host_din,
        input  req_valid, req_we, req_addr, req_wdata,
        output host_dout, req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/host_bram_arbiter.sv
// -----------------------------------------------------------------------------
// host_bram_arbiter
// Owns a single-port on-chip buffer shared between the XDMA host BRAM port and
// NUM_REQ kernel requesters. The host cannot be stalled and always wins; kernel
// requesters are served round-robin (valid/ready) in cycles the host is idle.
// Ports:
//   host_clk   : single clock
//   host_rstn  : synchronous active-low reset
//   bus        : host_bram_arbiter_if.slave (host port + kernel req/rsp)
//   perf_host_cycles, perf_conflict_cycles : only when ARB_PERF_EN is defined
// Optional feature macro: ARB_PERF_EN (saturating 32-bit activity counters).
// -----------------------------------------------------------------------------
module host_bram_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 2,
    parameter int WADDR_W = ADDR_W - 2
) (
    input  logic                 host_clk,
    input  logic                 host_rstn,
    host_bram_arbiter_if.slave   bus
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]          perf_host_cycles,
    output logic [31:0]          perf_conflict_cycles
`endif
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << WADDR_W;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // ---------------- per-requester field unpacking ----------------
    logic [NUM_REQ-1:0][NB-1:0]      w_req_we;
    logic [NUM_REQ-1:0][WADDR_W-1:0] w_req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0]  w_req_wdata;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_req_we[gi]    = bus.req_we[gi*NB +: NB];
        assign w_req_addr[gi]  = bus.req_addr[gi*WADDR_W +: WADDR_W];
        assign w_req_wdata[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
    end

    // ---------------- round-robin grant ----------------
    logic [IDX_W-1:0] r_rr;
    logic [IDX_W-1:0] w_gnt_idx;
    logic             w_gnt_any;
    int               w_idx;

    // Scan starting at r_rr, wrapping; first valid requester wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_gnt_any && bus.req_valid[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = IDX_W'(w_idx);
            end
        end
    end

    // Kernel grant only when the host is idle; held off during reset so a
    // grant can never coincide with a reset edge.
    logic               w_kern_go;
    logic [NUM_REQ-1:0] w_ready;

    assign w_kern_go = w_gnt_any && !bus.host_en && host_rstn;

    always_comb begin
        w_ready = '0;
        if (w_kern_go) w_ready[w_gnt_idx] = 1'b1;
    end

    assign bus.req_ready = w_ready;

    // ---------------- memory port mux ----------------
    logic [WADDR_W-1:0] w_addr;
    logic [NB-1:0]      w_we;
    logic [NB-1:0]      w_we_eff;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_acc;
    logic               w_rd;

    always_comb begin
        w_addr  = w_req_addr[w_gnt_idx];
        w_we    = '0;
        w_wdata = w_req_wdata[w_gnt_idx];
        if (bus.host_en) begin
            w_addr  = WADDR_W'(bus.host_addr[ADDR_W-1:2]);
            w_we    = bus.host_we;
            w_wdata = bus.host_din;
        end else if (w_kern_go) begin
            w_we    = w_req_we[w_gnt_idx];
        end
    end

    assign w_acc    = (bus.host_en || w_kern_go) && host_rstn;
    assign w_rd     = w_acc && (w_we == '0);
    // Writes are suppressed on a reset edge.
    assign w_we_eff = host_rstn ? w_we : '0;

    // Byte-lane bit [1:0] of the host address is intentionally ignored.
    logic w_unused;
    assign w_unused = ^bus.host_addr[1:0];

    // ---------------- RAM array (not reset) ----------------
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge host_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (w_we_eff[b]) r_mem[w_addr][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
    end

    // ---------------- read register / response ----------------
    // Shared output register for host_dout and rsp_rdata; only loads on reads,
    // so it holds across write and idle cycles.
    logic [DATA_W-1:0]  r_rdata;
    logic [NUM_REQ-1:0] r_rsp_valid;

    always_ff @(posedge host_clk) begin
        if (!host_rstn) begin
            r_rdata     <= '0;
            r_rsp_valid <= '0;
            r_rr        <= '0;
        end else begin
            if (w_rd) r_rdata <= r_mem[w_addr];
            r_rsp_valid <= (w_kern_go && (w_we == '0)) ? w_ready : '0;
            if (w_kern_go) begin
                r_rr <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign bus.host_dout = r_rdata;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_valid = r_rsp_valid;

`ifdef ARB_PERF_EN
    // ---------------- saturating activity counters ----------------
    logic [31:0] r_perf_host;
    logic [31:0] r_perf_conf;

    always_ff @(posedge host_clk) begin
        if (!host_rstn) begin
            r_perf_host <= '0;
            r_perf_conf <= '0;
        end else if (bus.host_en) begin
            if (r_perf_host != 32'hFFFF_FFFF) r_perf_host <= r_perf_host + 32'd1;
            if ((bus.req_valid != '0) && (r_perf_conf != 32'hFFFF_FFFF))
                r_perf_conf <= r_perf_conf + 32'd1;
        end
    end

    assign perf_host_cycles     = r_perf_host;
    assign perf_conflict_cycles = r_perf_conf;
`endif

endmodule

// File: tb/tb_host_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_host_bram_arbiter
// Directed bench for host_bram_arbiter (NUM_REQ=2, ADDR_W=15, DATA_W=32).
// Inputs change 1 ns after the rising edge; registered outputs are checked
// right after the edge, combinational ready 1 ns after inputs change.
// -----------------------------------------------------------------------------
module tb_host_bram_arbiter;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 2;
    localparam int WADDR_W = ADDR_W - 2;

    logic host_clk = 1'b0;
    logic host_rstn;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 host_clk = ~host_clk;

    host_bram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REQ(NUM_REQ),
                           .WADDR_W(WADDR_W)) b ();

`ifdef ARB_PERF_EN
    logic [31:0] perf_h;
    logic [31:0] perf_c;
`endif

    host_bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REQ(NUM_REQ),
                        .WADDR_W(WADDR_W)) dut (
        .host_clk            (host_clk),
        .host_rstn           (host_rstn),
        .bus                 (b)
`ifdef ARB_PERF_EN
        ,
        .perf_host_cycles    (perf_h),
        .perf_conflict_cycles(perf_c)
`endif
    );

    task automatic tick();
        @(posedge host_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        host_rstn   = 1'b0;
        b.host_en   = 1'b0;
        b.host_we   = '0;
        b.host_addr = '0;
        b.host_din  = '0;
        b.req_valid = '0;
        b.req_we    = '0;
        b.req_addr  = '0;
        b.req_wdata = '0;
        tick();
        tick();

        // reset state: ready held low even with valid requests
        b.req_valid = 2'b11;
        #1 chk("rst_ready", 32'(b.req_ready), 32'h0);
        tick();
        chk("rst_dout", b.host_dout, 32'h0);
        chk("rst_rsp_valid", 32'(b.rsp_valid), 32'h0);
`ifdef ARB_PERF_EN
        chk("rst_perf_host", perf_h, 32'h0);
        chk("rst_perf_conf", perf_c, 32'h0);
`endif
        b.req_valid = '0;
        host_rstn   = 1'b1;

        // host full write then read back, latency 1
        b.host_en = 1'b1; b.host_we = 4'hF; b.host_addr = 15'h0010; b.host_din = 32'hDEADBEEF;
        tick();
        b.host_we = 4'h0;
        tick();
        chk("host_rd_full", b.host_dout, 32'hDEADBEEF);
        chk("host_no_rsp", 32'(b.rsp_valid), 32'h0);

        // partial byte write over existing data
        b.host_we = 4'hF; b.host_addr = 15'h0020; b.host_din = 32'hAAAAAAAA;
        tick();
        b.host_we = 4'h3; b.host_din = 32'h12345678;
        tick();
        b.host_we = 4'h0;
        tick();
        chk("host_rd_partial", b.host_dout, 32'hAAAA5678);
        b.host_en = 1'b0;

        // both requesters read continuously: grants alternate 0,1,0,1
        b.req_we    = '0;
        b.req_addr  = {13'd8, 13'd4};
        b.req_valid = 2'b11;
        #1 chk("rr_g0_ready", 32'(b.req_ready), 32'h1);
        tick();
        chk("rr_g0_rsp", 32'(b.rsp_valid), 32'h1);
        chk("rr_g0_data", b.rsp_rdata, 32'hDEADBEEF);
        chk("rr_g1_ready", 32'(b.req_ready), 32'h2);
        tick();
        chk("rr_g1_rsp", 32'(b.rsp_valid), 32'h2);
        chk("rr_g1_data", b.rsp_rdata, 32'hAAAA5678);
        chk("rr_g2_ready", 32'(b.req_ready), 32'h1);
        tick();
        chk("rr_g2_rsp", 32'(b.rsp_valid), 32'h1);
        chk("rr_g3_ready", 32'(b.req_ready), 32'h2);
        tick();
        chk("rr_g3_rsp", 32'(b.rsp_valid), 32'h2);
        b.req_valid = 2'b00;
        #1 chk("idle_ready", 32'(b.req_ready), 32'h0);
        tick();
        chk("idle_rsp", 32'(b.rsp_valid), 32'h0);

        // host owns the RAM for 3 cycles while both kernels wait
        b.host_en = 1'b1; b.host_we = 4'h0; b.host_addr = 15'h0010;
        b.req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1 chk("host_block_ready", 32'(b.req_ready), 32'h0);
            tick();
        end
        b.host_en = 1'b0;
        #1 chk("after_host_ready0", 32'(b.req_ready), 32'h1);
`ifdef ARB_PERF_EN
        chk("perf_host", perf_h, 32'd8);
        chk("perf_conf", perf_c, 32'd3);
`endif
        tick();
        chk("after_host_rsp0", 32'(b.rsp_valid), 32'h1);
        chk("after_host_ready1", 32'(b.req_ready), 32'h2);
        tick();
        chk("after_host_rsp1", 32'(b.rsp_valid), 32'h2);
        chk("after_host_data1", b.rsp_rdata, 32'hAAAA5678);
        b.req_valid = 2'b00;

        // req1 writes 0x55 to word 4, req0 reads word 4 next cycle
        b.req_valid = 2'b10;
        b.req_we    = {4'hF, 4'h0};
        b.req_addr  = {13'd4, 13'd4};
        b.req_wdata = {32'h00000055, 32'h0};
        #1 chk("ord_wr_ready", 32'(b.req_ready), 32'h2);
        tick();
        chk("ord_wr_no_rsp", 32'(b.rsp_valid), 32'h0);
        b.req_valid = 2'b01;
        b.req_we    = '0;
        #1 chk("ord_rd_ready", 32'(b.req_ready), 32'h1);
        tick();
        chk("ord_rd_rsp", 32'(b.rsp_valid), 32'h1);
        chk("ord_rd_data", b.rsp_rdata, 32'h00000055);

        // reset the cycle after a read grant; rr leaves at 1 then must restart at 0
        #1 chk("rst2_grant_ready", 32'(b.req_ready), 32'h1);
        tick();
        host_rstn   = 1'b0;
        b.req_valid = 2'b11;
        #1 chk("rst2_ready_low", 32'(b.req_ready), 32'h0);
        tick();
        chk("rst2_rsp", 32'(b.rsp_valid), 32'h0);
        chk("rst2_dout", b.host_dout, 32'h0);
        chk("rst2_rdata", b.rsp_rdata, 32'h0);
        chk("rst2_ready", 32'(b.req_ready), 32'h0);
`ifdef ARB_PERF_EN
        chk("rst2_perf_host", perf_h, 32'h0);
        chk("rst2_perf_conf", perf_c, 32'h0);
`endif
        tick();
        chk("rst2_rsp_hold", 32'(b.rsp_valid), 32'h0);
        host_rstn = 1'b1;
        #1 chk("rst2_first_grant", 32'(b.req_ready), 32'h1);
        tick();
        chk("rst2_first_rsp", 32'(b.rsp_valid), 32'h1);
        chk("rst2_first_data", b.rsp_rdata, 32'h00000055);
        b.req_valid = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
